// File: rtl/fifo_seq_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_seq_pkg
// Brief  : Shared types and constants for the FIFO sequence sink.
//          Holds the FSM state encoding, the LFSR feedback taps, the default
//          packet width and the packet type.
// Rev    : 1.0  initial release
// ============================================================================
package fifo_seq_pkg;

  localparam int unsigned PKT_W_DEFAULT = 8;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [PKT_W_DEFAULT-1:0] pkt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

endpackage : fifo_seq_pkg
`default_nettype wire

// File: rtl/fifo_seq_sink_lfsr.sv
`default_nettype none
// ============================================================================
// Module : seq_lfsr16
// Brief  : 16-bit Fibonacci LFSR used to randomise sink back-pressure.
//          Shifts left by one each cycle advance is high; feedback is the
//          XOR of the tapped bits.
// Ports  : clock      - clock
//          reset      - synchronous, active-high; loads SEED
//          advance    - step the register this cycle
//          lfsr_state - current 16-bit register contents
// Rev    : 1.0  initial release
// ============================================================================
module seq_lfsr16
  import fifo_seq_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] lfsr_state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        feedback;

  always_comb begin
    feedback = ^(lfsr_q & LFSR_TAPS);
    lfsr_d   = lfsr_q;
    if (advance) begin
      lfsr_d = {lfsr_q[14:0], feedback};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_state = lfsr_q;

endmodule : seq_lfsr16
`default_nettype wire

// File: rtl/fifo_seq_sink.sv
`default_nettype none
// ============================================================================
// Module : fifo_seq_sink
// Brief  : Dequeue-side responder for a valid/ready packet FIFO. Accepts
//          packets, checks they follow 0,1,2,... (mod 2^PKT_W), applies
//          bounded back-pressure and flags mismatches and starvation.
// Config : FIFO_SEQ_SINK_RAND_STALL_EN - when defined, out_ready is driven
//          from an LFSR (~25% stalls, at most MAX_STALL in a row); otherwise
//          out_ready is held high throughout RUN.
// Ports  : clock, reset (sync, active-high)
//          enable      - consume while high; low returns to IDLE
//          out_valid   - FIFO has a packet
//          out_ready   - registered accept strobe
//          packet_out  - packet from the FIFO
//          rx_count    - accepted handshakes
//          err_count   - saturating mismatch count
//          mismatch    - sticky mismatch flag
//          first_exp   - expected value at first mismatch
//          first_got   - received value at first mismatch
//          timeout     - sticky watchdog expiry
//          state       - FSM state encoding
// Rev    : 1.0  initial release
// ============================================================================
module fifo_seq_sink
  import fifo_seq_pkg::*;
#(
  parameter int unsigned PKT_W       = PKT_W_DEFAULT,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned MAX_STALL   = 7,
  parameter int unsigned WDOG_CYCLES = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned STOP_ON_ERR = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             out_valid,
  output logic             out_ready,
  input  logic [PKT_W-1:0] packet_out,
  output logic [CNT_W-1:0] rx_count,
  output logic [ERR_W-1:0] err_count,
  output logic             mismatch,
  output logic [PKT_W-1:0] first_exp,
  output logic [PKT_W-1:0] first_got,
  output logic             timeout,
  output logic [1:0]       state
);

  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  state_t             state_q, state_d;
  logic               out_ready_q, out_ready_d;
  logic [CNT_W-1:0]   rx_count_q, rx_count_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               mismatch_q, mismatch_d;
  logic [PKT_W-1:0]   first_exp_q, first_exp_d;
  logic [PKT_W-1:0]   first_got_q, first_got_d;
  logic               timeout_q, timeout_d;
  logic [PKT_W-1:0]   expected_q, expected_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;

  logic run_hs;
  logic pkt_err;
  logic ready_policy;

`ifdef FIFO_SEQ_SINK_RAND_STALL_EN
  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [15:0]        lfsr_value;

  seq_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .advance   (state_q == RUN),
    .lfsr_state(lfsr_value)
  );

  // stall_cnt counts consecutive low-ready RUN cycles including the current
  // one; forcing ready once it hits MAX_STALL caps any stall run at MAX_STALL.
  always_comb begin
    ready_policy = 1'b1;
    stall_cnt_d  = '0;
    if (state_q == IDLE) begin
      // The first RUN cycle always has ready low, so it starts the count.
      stall_cnt_d = STALL_W'(1);
    end else if (state_q == RUN) begin
      if (stall_cnt_q == STALL_W'(MAX_STALL)) begin
        ready_policy = 1'b1;
      end else if (lfsr_value[1:0] != 2'b00) begin
        ready_policy = 1'b1;
      end else begin
        ready_policy = 1'b0;
        stall_cnt_d  = stall_cnt_q + STALL_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  always_comb begin
    ready_policy = 1'b1;
  end
`endif

  always_comb begin
    state_d     = state_q;
    out_ready_d = 1'b0;
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    mismatch_d  = mismatch_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    timeout_d   = timeout_q;
    expected_d  = expected_q;
    wdog_d      = '0;

    // Handshakes are only counted in RUN; out_ready is never high elsewhere.
    run_hs  = (state_q == RUN) && out_valid && out_ready_q;
    pkt_err = run_hs && (packet_out != expected_q);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pkt_err && (STOP_ON_ERR != 0)) begin
          state_d = FAIL;
        end else if (!enable) begin
          state_d = IDLE;
        end else begin
          out_ready_d = ready_policy;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (run_hs) begin
      rx_count_d = rx_count_q + CNT_W'(1);
      expected_d = expected_q + PKT_W'(1);
    end

    if (pkt_err) begin
      mismatch_d = 1'b1;
      if (err_count_q != '1) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
      if (!mismatch_q) begin
        first_exp_d = expected_q;
        first_got_d = packet_out;
      end
    end

    // Watchdog: raise timeout on the cycle the counter reaches its limit.
    if (state_q == RUN && !run_hs) begin
      if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        wdog_d = wdog_q;
      end else begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (wdog_d == WDOG_W'(WDOG_CYCLES - 1)) begin
          timeout_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      out_ready_q <= 1'b0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      mismatch_q  <= 1'b0;
      first_exp_q <= '0;
      first_got_q <= '0;
      timeout_q   <= 1'b0;
      expected_q  <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_ready_q <= out_ready_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      mismatch_q  <= mismatch_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
      timeout_q   <= timeout_d;
      expected_q  <= expected_d;
      wdog_q      <= wdog_d;
    end
  end

  assign out_ready = out_ready_q;
  assign rx_count  = rx_count_q;
  assign err_count = err_count_q;
  assign mismatch  = mismatch_q;
  assign first_exp = first_exp_q;
  assign first_got = first_got_q;
  assign timeout   = timeout_q;
  assign state     = state_q;

endmodule : fifo_seq_sink
`default_nettype wire

// File: tb/tb_fifo_seq_sink.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_seq_sink
// Brief  : Directed self-checking bench for fifo_seq_sink (default params).
//          Inputs are driven and outputs sampled on the falling clock edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fifo_seq_sink;
  import fifo_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        out_valid;
  logic        out_ready;
  pkt_t        packet_out;
  logic [31:0] rx_count;
  logic [15:0] err_count;
  logic        mismatch;
  pkt_t        first_exp;
  pkt_t        first_got;
  logic        timeout;
  logic [1:0]  state;

  int checks = 0;
  int passed = 0;

  fifo_seq_sink dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .packet_out(packet_out),
    .rx_count  (rx_count),
    .err_count (err_count),
    .mismatch  (mismatch),
    .first_exp (first_exp),
    .first_got (first_got),
    .timeout   (timeout),
    .state     (state)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset      = 1'b1;
    enable     = 1'b0;
    out_valid  = 1'b0;
    packet_out = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Upstream model: present first+idx, advance on each observed handshake.
  task automatic send_seq(input int first, input int n, input int budget, output int got);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < budget) begin
      out_valid  = 1'b1;
      packet_out = 8'(first + idx);
      if (out_ready) idx++;
      @(negedge clock);
      cyc++;
    end
    out_valid = 1'b0;
    got = idx;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", out_ready); else passed++;
    checks++; if (rx_count !== 32'd0) $display("FAIL reset_rx got=%0d exp=0", rx_count); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL reset_err got=%0d exp=0", err_count); else passed++;
    checks++; if ({mismatch, timeout} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {mismatch, timeout}); else passed++;
    checks++; if ({first_exp, first_got} !== 16'h0000) $display("FAIL reset_first got=%h exp=0000", {first_exp, first_got}); else passed++;
    checks++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else passed++;
  endtask

  task automatic test_ordered_stream();
    int got;
    do_reset();
    enable = 1'b1;
    send_seq(0, 300, 400, got);
    checks++; if (got !== 300) $display("FAIL ordered_hs got=%0d exp=300", got); else passed++;
    checks++; if (rx_count !== 32'd300) $display("FAIL ordered_rx got=%0d exp=300", rx_count); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL ordered_err got=%0d exp=0", err_count); else passed++;
    checks++; if ({mismatch, timeout} !== 2'b00) $display("FAIL ordered_flags got=%b exp=00", {mismatch, timeout}); else passed++;
    checks++; if (state !== 2'd1) $display("FAIL ordered_state got=%0d exp=1", state); else passed++;
  endtask

  task automatic test_corruption();
    pkt_t stream [5] = '{8'd0, 8'd1, 8'd2, 8'd9, 8'd4};
    int idx = 0;
    int cyc = 0;
    int ready_hi = 0;
    do_reset();
    enable = 1'b1;
    while (idx < 4 && cyc < 50) begin
      out_valid  = 1'b1;
      packet_out = stream[idx];
      if (out_ready) idx++;
      @(negedge clock);
      cyc++;
    end
    checks++; if (idx !== 4) $display("FAIL corrupt_hs got=%0d exp=4", idx); else passed++;
    packet_out = stream[4];
    repeat (10) begin
      if (out_ready) ready_hi++;
      @(negedge clock);
    end
    out_valid = 1'b0;
    checks++; if (ready_hi !== 0) $display("FAIL corrupt_ready_after got=%0d exp=0", ready_hi); else passed++;
    checks++; if (mismatch !== 1'b1) $display("FAIL corrupt_mismatch got=%0b exp=1", mismatch); else passed++;
    checks++; if (first_exp !== 8'd3) $display("FAIL corrupt_first_exp got=%0d exp=3", first_exp); else passed++;
    checks++; if (first_got !== 8'd9) $display("FAIL corrupt_first_got got=%0d exp=9", first_got); else passed++;
    checks++; if (err_count !== 16'd1) $display("FAIL corrupt_err got=%0d exp=1", err_count); else passed++;
    checks++; if (state !== 2'd2) $display("FAIL corrupt_state got=%0d exp=2", state); else passed++;
    checks++; if (rx_count !== 32'd4) $display("FAIL corrupt_rx got=%0d exp=4", rx_count); else passed++;
  endtask

  task automatic test_starvation();
    int got;
    do_reset();
    enable = 1'b1;
    @(negedge clock);              // first RUN cycle
    repeat (254) @(negedge clock); // RUN cycle 255
    checks++; if (timeout !== 1'b0) $display("FAIL starve_early got=%0b exp=0", timeout); else passed++;
    @(negedge clock);              // RUN cycle 256
    checks++; if (timeout !== 1'b1) $display("FAIL starve_timeout got=%0b exp=1", timeout); else passed++;
    send_seq(0, 1, 50, got);
    checks++; if (rx_count !== 32'd1) $display("FAIL starve_rx got=%0d exp=1", rx_count); else passed++;
    checks++; if (timeout !== 1'b1) $display("FAIL starve_sticky got=%0b exp=1", timeout); else passed++;
  endtask

  task automatic test_mid_stream();
    int got;
    int cyc = 0;
    int gap_hi = 0;
    do_reset();
    enable = 1'b1;
    send_seq(0, 9, 50, got);
    // Tenth packet handshakes in the same cycle enable drops.
    out_valid  = 1'b1;
    packet_out = 8'd9;
    while (!out_ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    enable = 1'b0;
    @(negedge clock);
    out_valid = 1'b0;
    checks++; if (rx_count !== 32'd10) $display("FAIL mid_rx_first got=%0d exp=10", rx_count); else passed++;
    repeat (5) begin
      if (out_ready) gap_hi++;
      @(negedge clock);
    end
    checks++; if (gap_hi !== 0) $display("FAIL mid_gap_ready got=%0d exp=0", gap_hi); else passed++;
    checks++; if (state !== 2'd0) $display("FAIL mid_gap_state got=%0d exp=0", state); else passed++;
    enable = 1'b1;
    send_seq(10, 10, 60, got);
    checks++; if (rx_count !== 32'd20) $display("FAIL mid_rx got=%0d exp=20", rx_count); else passed++;
    checks++; if ({err_count, mismatch} !== 17'd0) $display("FAIL mid_err got=%0d/%0b exp=0/0", err_count, mismatch); else passed++;
    // Reset with a handshake in flight.
    out_valid  = 1'b1;
    packet_out = 8'd20;
    cyc = 0;
    while (!out_ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({out_ready, mismatch, timeout} !== 3'b000) $display("FAIL midrst_flags got=%b exp=000", {out_ready, mismatch, timeout}); else passed++;
    checks++; if (rx_count !== 32'd0) $display("FAIL midrst_rx got=%0d exp=0", rx_count); else passed++;
    checks++; if ({err_count, first_exp, first_got} !== 32'd0) $display("FAIL midrst_err got=%h exp=0", {err_count, first_exp, first_got}); else passed++;
    checks++; if (state !== 2'd0) $display("FAIL midrst_state got=%0d exp=0", state); else passed++;
    reset     = 1'b0;
    out_valid = 1'b0;
    enable    = 1'b0;
  endtask

`ifdef FIFO_SEQ_SINK_RAND_STALL_EN
  task automatic test_rand_stall();
    int run_low = 0;
    int max_low = 0;
    int hs = 0;
    do_reset();
    enable    = 1'b1;
    out_valid = 1'b1;
    repeat (1000) begin
      packet_out = 8'(hs);
      if (state == 2'd1 && !out_ready) begin
        run_low++;
        if (run_low > max_low) max_low = run_low;
      end else begin
        run_low = 0;
      end
      if (out_ready) hs++;
      @(negedge clock);
    end
    out_valid = 1'b0;
    checks++; if (max_low > 7) $display("FAIL rand_max_stall got=%0d exp<=7", max_low); else passed++;
    checks++; if (rx_count !== 32'(hs)) $display("FAIL rand_rx got=%0d exp=%0d", rx_count, hs); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL rand_err got=%0d exp=0", err_count); else passed++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout got=expired exp=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_ordered_stream();
    test_corruption();
    test_starvation();
    test_mid_stream();
`ifdef FIFO_SEQ_SINK_RAND_STALL_EN
    test_rand_stall();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_fifo_seq_sink
`default_nettype wire

// File: doc/fifo_seq_sink.md
Name: fifo_seq_sink

Overview:
- Dequeue-side responder for the 8-bit packet valid/ready FIFO interface.
- Consumes packets from a FIFO output and checks they form the natural-number sequence 0,1,2,… (mod 2^PKT_W).
- Drives bounded back-pressure so full-FIFO and stall paths get exercised, and flags mismatches and starvation.
- Instantiated in simulation benches and as a synthesizable checker in FPGA bring-up, as the in-RTL counterpart of the sequence-numbered stimulus on the enqueue side.

Parameters:
- PKT_W, 8, packet width; the expected sequence wraps modulo 2^PKT_W.
- CNT_W, 32, width of the received-packet counter.
- ERR_W, 16, width of the saturating error counter.
- MAX_STALL, 7, maximum consecutive RUN cycles with out_ready low; must be ≥1.
- WDOG_CYCLES, 256, cycles without a handshake before timeout is raised.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- STOP_ON_ERR, 1, if 1 the block enters FAIL on the first mismatch and stops consuming.

Ports:
- clock, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- enable, in, 1, start/continue consuming; low returns the block to IDLE.
- out_valid, in, 1, FIFO has a packet.
- out_ready, out, 1, sink accepts a packet this cycle.
- packet_out, in, PKT_W, packet from the FIFO.
- rx_count, out, CNT_W, number of handshakes accepted.
- err_count, out, ERR_W, mismatches seen; saturates at all-ones.
- mismatch, out, 1, sticky: at least one mismatch has occurred.
- first_exp, out, PKT_W, expected value at the first mismatch.
- first_got, out, PKT_W, received value at the first mismatch.
- timeout, out, 1, sticky watchdog expiry.
- state, out, 2, current FSM state encoding.

Behaviour:
- Reset values: out_ready=0, rx_count=0, err_count=0, mismatch=0, first_exp=0, first_got=0, timeout=0, expected=0, stall_cnt=0, wdog=0, lfsr=LFSR_SEED, state=IDLE.
- Reset has priority over all other inputs. Reset asserted mid-operation clears everything in the next cycle, including any handshake in flight.
- Handshake = out_valid && out_ready, sampled at posedge. out_ready is a registered output with no combinational path from out_valid.
- FSM states:
  - IDLE (0): out_ready=0. Go to RUN when enable=1.
  - RUN (1): out_ready follows the stall policy. Go to IDLE when enable=0; go to FAIL on a mismatch if STOP_ON_ERR=1.
  - FAIL (2): out_ready=0. Exit only via reset.
  - Encoding 3 is unused; if reached, go to IDLE.
- On handshake in RUN:
  - rx_count increments.
  - expected <= expected+1, wrapping 2^PKT_W-1 -> 0.
  - If packet_out != expected: err_count increments (saturating), mismatch <= 1.
  - The first mismatch only latches first_exp/first_got.
  - expected always advances on a handshake, mismatch or not. Resynchronisation is not attempted.
- Stall policy (RUN only):
  - Each cycle the stall decision sets out_ready for the next cycle.
  - If stall_cnt == MAX_STALL, out_ready is forced to 1 and stall_cnt resets to 0. This guarantees out_ready recurs at least once every MAX_STALL+1 cycles (liveness).
- Watchdog:
  - Counts RUN cycles since the last handshake; clears on handshake or on leaving RUN.
  - When it reaches WDOG_CYCLES-1, timeout <= 1 (sticky) and the counter holds.
  - Counting is independent of out_valid, so an empty upstream also times out.
- enable dropping mid-stream:
  - out_ready=0 from the next cycle.
  - A handshake in the current cycle is still checked.
  - expected and the counters are retained, so re-enable resumes the sequence.

Optional Feature:
- Macro: FIFO_SEQ_SINK_RAND_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances every RUN cycle.
  - out_ready_next = (lfsr[1:0] != 2'b00), giving ≈25% stall probability, subject to the MAX_STALL override.
- When undefined:
  - No LFSR is instantiated.
  - out_ready=1 every RUN cycle.
  - stall_cnt is constant 0.

Decomposition:
- Package fifo_seq_pkg holds:
  - the state enum: IDLE=2'd0, RUN=2'd1, FAIL=2'd2;
  - LFSR_TAPS constant 16'hB400;
  - the default PKT_W constant;
  - the pkt_t typedef logic [PKT_W-1:0].
- Sub-module seq_lfsr16: clock, reset, advance, seed parameter, 16-bit state out. It is instantiated only under the macro.

Test Plan:
- Ordered stream: upstream presents 0..299 back-to-back, enable=1, macro off -> rx_count=300, expected wraps 255->0 at packet 256, err_count=0, mismatch=0, timeout=0.
- Corruption: stream 0,1,2,9,4, STOP_ON_ERR=1 -> mismatch=1, first_exp=3, first_got=9, err_count=1, state=FAIL, out_ready=0 thereafter, rx_count=4.
- Starvation: enable=1, out_valid held 0 for 256 cycles -> timeout=1 on the 256th RUN cycle; a subsequent handshake does not clear it.
- Random stall (macro on): 1000 cycles of continuous out_valid -> never more than MAX_STALL=7 consecutive out_ready=0 cycles in RUN; rx_count equals the observed handshake count; no errors.
- Mid-stream control: after 10 handshakes drop enable for 5 cycles, then re-enable and send 10..19 -> out_ready=0 during the gap, err_count=0, rx_count=20. Then assert reset -> all outputs return to reset values next cycle.
